conv_result_drain: RTL and testbench

- Read-side controller for the 45-bit convolution result FIFO.
- Drives the FIFO read enable and captures its registered output.
- Rounds, shifts and saturates each signed 45-bit result to OUT_W bits.
- Presents results downstream on a valid/ready interface with frame framing (out_last, frame_done); sits between the result FIFO and the output writer.

---
 rtl/conv_result_drain_if.sv | 36 +++
 rtl/conv_result_drain.sv | 148 ++++++++++++++
 tb/tb_conv_result_drain.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_result_drain_if.sv
// Bundles the FIFO read side and the downstream result stream of conv_result_drain.
//
// Handshake rules:
//   FIFO side: the FIFO pops when fifo_en=1 and fifo_empty=0. Its registered data
//   appears on fifo_data/fifo_valid one cycle after the pop. fifo_valid keeps its
//   value while fifo_en=0, so it is only meaningful in the cycle after a pop.
//   Output side: a result transfers when out_valid=1 and out_ready=1 in the same
//   cycle. While out_valid=1 and out_ready=0, out_data and out_last hold stable.
//   out_last marks the final result of a frame.
interface conv_result_drain_if #(
  parameter int OUT_W = 16
);
  logic             start;
  logic [44:0]      fifo_data;
  logic             fifo_valid;
  logic             fifo_empty;
  logic             fifo_en;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             frame_done;
  logic             busy;
  logic [15:0]      sat_count;
  logic [1:0]       state_dbg;

  modport slave (
    input  start, fifo_data, fifo_valid, fifo_empty, out_ready,
    output fifo_en, out_data, out_valid, out_last, frame_done, busy, sat_count, state_dbg
  );

  modport master (
    output start, fifo_data, fifo_valid, fifo_empty, out_ready,
    input  fifo_en, out_data, out_valid, out_last, frame_done, busy, sat_count, state_dbg
  );
endinterface

// File: rtl/conv_result_drain.sv
// Drains a fixed number of 45-bit convolution results per frame from the result
// FIFO, rounds/shifts/saturates each one to OUT_W bits and streams it out through
// a 3-entry skid buffer with frame framing (out_last, frame_done).
module conv_result_drain #(
  parameter int RESULTS_PER_FRAME = 15,
  parameter int OUT_W             = 16,
  parameter int SHIFT             = 8
) (
  input logic clk,
  input logic reset,
  conv_result_drain_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [16:0]        RPF     = 17'(RESULTS_PER_FRAME);
  localparam logic signed [45:0] RND     = (46'sd1 <<< SHIFT) >>> 1;
  localparam logic signed [45:0] SAT_MAX = (46'sd1 <<< (OUT_W - 1)) - 46'sd1;
  localparam logic signed [45:0] SAT_MIN = -(46'sd1 <<< (OUT_W - 1));

  state_t            state_q, state_d;
  logic [16:0]       issued_q, issued_d;
  logic [16:0]       captured_q, captured_d;
  logic              pop_d_q;
  logic [15:0]       sat_q, sat_d;
  logic [OUT_W-1:0]  skid_data_q [3];
  logic [2:0]        skid_last_q;
  logic [1:0]        rd_ptr_q, wr_ptr_q, occ_q;

  logic              fifo_en_c, pop, capture, rerequest;
  logic              out_valid_c, hs, head_last, frame_start;
  logic              busy_c, done_c;
  logic signed [45:0] ext, rounded, shifted;
  logic [OUT_W-1:0]  res;
  logic              clamp;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Pop issue: stop requesting once the frame quota is issued or the skid
  // buffer plus the word in flight would overflow it.
  always_comb begin
    fifo_en_c   = (state_q == S_RUN) && (issued_q < RPF) &&
                  (({1'b0, occ_q} + {2'b0, pop_d_q}) < 3'd3);
    pop         = fifo_en_c & ~bus.fifo_empty;
    capture     = pop_d_q & bus.fifo_valid;
    rerequest   = pop_d_q & ~bus.fifo_valid;
    out_valid_c = (occ_q != 2'd0);
    hs          = out_valid_c & bus.out_ready;
    head_last   = skid_last_q[rd_ptr_q];
    frame_start = (state_q == S_IDLE) & bus.start;
  end

  // Round half up, arithmetic shift, clamp to the signed OUT_W range.
  always_comb begin
    ext     = {bus.fifo_data[44], bus.fifo_data};
    rounded = ext + RND;
    shifted = rounded >>> SHIFT;
    clamp   = 1'b0;
    res     = shifted[OUT_W-1:0];
    if (shifted > SAT_MAX) begin
      res   = SAT_MAX[OUT_W-1:0];
      clamp = 1'b1;
    end else if (shifted < SAT_MIN) begin
      res   = SAT_MIN[OUT_W-1:0];
      clamp = 1'b1;
    end
  end

  // Frame FSM next state and state-derived outputs.
  always_comb begin
    state_d = state_q;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_RUN;
      S_RUN: begin
        busy_c = 1'b1;
        if (hs && head_last) state_d = S_DONE;
      end
      S_DONE: begin
        busy_c  = 1'b1;
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Frame counters: a pop whose data never turned valid is given back to issued.
  always_comb begin
    if (frame_start) begin
      issued_d   = '0;
      captured_d = '0;
      sat_d      = '0;
    end else begin
      issued_d   = issued_q + 17'(pop) - 17'(rerequest);
      captured_d = captured_q + 17'(capture);
      sat_d      = (capture && clamp && (sat_q != 16'hFFFF)) ? sat_q + 16'd1 : sat_q;
    end
  end

  // State, counters and skid buffer registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      issued_q   <= '0;
      captured_q <= '0;
      pop_d_q    <= 1'b0;
      sat_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= '0;
      skid_last_q <= '0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      captured_q <= captured_d;
      pop_d_q    <= pop;
      sat_q      <= sat_d;
      if (capture) begin
        skid_data_q[wr_ptr_q] <= res;
        skid_last_q[wr_ptr_q] <= (captured_q == RPF - 17'd1);
        wr_ptr_q              <= ptr_inc(wr_ptr_q);
      end
      if (hs) rd_ptr_q <= ptr_inc(rd_ptr_q);
      occ_q <= occ_q + 2'(capture) - 2'(hs);
    end
  end

  // Output data is forced to zero whenever nothing valid is presented.
  always_comb begin
    bus.fifo_en    = fifo_en_c;
    bus.out_valid  = out_valid_c;
    bus.out_data   = out_valid_c ? skid_data_q[rd_ptr_q] : '0;
    bus.out_last   = out_valid_c & head_last;
    bus.frame_done = done_c;
    bus.busy       = busy_c;
    bus.sat_count  = sat_q;
    bus.state_dbg  = state_q;
  end

endmodule

// File: tb/tb_conv_result_drain.sv
// Bench for conv_result_drain: behavioural result FIFO, scoreboard fed by every
// pushed word, a table of hand-computed rounding/saturation vectors and a few
// multi-cycle sequences (latency, backpressure, starvation, mid-frame reset).
module tb_conv_result_drain;
  localparam int RPF   = 15;
  localparam int OUT_W = 16;
  localparam int SHIFT = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv_result_drain_if #(.OUT_W(OUT_W)) bus ();

  conv_result_drain #(
    .RESULTS_PER_FRAME(RPF),
    .OUT_W(OUT_W),
    .SHIFT(SHIFT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- result FIFO model ----------------
  logic [44:0] mem [0:1023];
  int          wr_idx = 0;
  int          rd_idx = 0;
  bit          flush_req = 1'b0;
  logic [44:0] fifo_data_r = '0;
  logic        fifo_valid_r = 1'b0;

  assign bus.fifo_empty = (rd_idx == wr_idx);
  assign bus.fifo_data  = fifo_data_r;
  assign bus.fifo_valid = fifo_valid_r;

  always @(posedge clk) begin
    if (flush_req) begin
      rd_idx <= wr_idx;
    end else if (bus.fifo_en) begin
      if (rd_idx != wr_idx) begin
        fifo_data_r  <= mem[rd_idx];
        fifo_valid_r <= 1'b1;
        rd_idx       <= rd_idx + 1;
      end else begin
        fifo_valid_r <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [44:0] exp_q[$];
  bit   sb_en = 1'b1;
  int   f_cnt, exp_sat, n_out, n_last, n_done, cyc = 0;
  int   first_en, first_val, first_hs, last_hs, done_cyc;
  logic s_valid, s_ready, s_last, s_done, s_en, s_busy, hs;
  logic [OUT_W-1:0] s_data, prev_data;
  bit   stall_prev = 1'b0;

  typedef struct {
    longint din;
    longint dout;
    bit     sat;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: round half up, floor-divide by 2^SHIFT, clamp to signed OUT_W.
  function automatic longint model_out(input logic [44:0] w, output bit sat);
    longint x  = longint'($signed(w));
    longint d  = longint'(1) << SHIFT;
    longint v  = x + d / 2;
    longint q  = (v >= 0) ? v / d : -((-v + d - 1) / d);
    longint hi = (longint'(1) << (OUT_W - 1)) - 1;
    longint lo = -hi - 1;
    sat = 1'b0;
    if (q > hi) begin q = hi; sat = 1'b1; end
    if (q < lo) begin q = lo; sat = 1'b1; end
    return q;
  endfunction

  function automatic logic [44:0] rand_word();
    longint r;
    if ($urandom_range(0, 1) == 0) begin
      r = longint'($urandom_range(0, 1 << 24)) - longint'(1 << 23);
    end else begin
      r = {$urandom(), $urandom()};
    end
    return r[44:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_word(input logic [44:0] w);
    mem[wr_idx] = w;
    wr_idx++;
    exp_q.push_back(w);
  endtask

  // One clock: sample outputs mid-cycle, score, then advance past the edge.
  task automatic cycle();
    logic [44:0] w;
    longint e;
    bit sat;
    #2;
    s_valid = bus.out_valid;
    s_ready = bus.out_ready;
    s_data  = bus.out_data;
    s_last  = bus.out_last;
    s_done  = bus.frame_done;
    s_en    = bus.fifo_en;
    s_busy  = bus.busy;
    hs      = s_valid & s_ready;
    if (stall_prev) begin
      chk("stall_valid", s_valid, 1);
      chk("stall_data", longint'($signed(s_data)), longint'($signed(prev_data)));
    end
    stall_prev = s_valid & ~s_ready & reset;
    prev_data  = s_data;
    if (s_en && first_en < 0) first_en = cyc;
    if (s_valid && first_val < 0) first_val = cyc;
    if (hs) begin
      n_out++;
      if (s_last) n_last++;
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
      if (sb_en) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_output", 1, 0);
        end else begin
          w = exp_q.pop_front();
          e = model_out(w, sat);
          chk("sb_data", longint'($signed(s_data)), e);
          chk("sb_last", s_last, (f_cnt == RPF - 1));
          if (sat) exp_sat++;
        end
        f_cnt++;
      end
    end
    if (s_done) begin
      n_done++;
      done_cyc = cyc;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    f_cnt = 0; exp_sat = 0; n_out = 0; n_last = 0; n_done = 0;
    first_en = -1; first_val = -1; first_hs = -1; last_hs = -1; done_cyc = -1;
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
  endtask

  // Discard whatever the FIFO model still holds (DUT must be idle).
  task automatic drain_idle();
    flush_req = 1'b1;
    cycle();
    flush_req = 1'b0;
    exp_q.delete();
  endtask

  // ready_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
  // data_mode: 0 -> k<<8, 1 -> random. gap<0 -> random push spacing.
  task automatic run_frame(input int ready_mode, input int data_mode, input int pre,
                           input int total, input int gap);
    int pushed = 0;
    int gap_cnt = 0;
    int budget = 0;
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < pre; k++) begin
      push_word((data_mode == 0) ? 45'(longint'(pushed) << 8) : rand_word());
      pushed++;
    end
    start_frame();
    while (n_done == 0 && budget < 600) begin
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = pat[cyc % 4];
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (pushed < total) begin
        if (gap_cnt == 0) begin
          push_word((data_mode == 0) ? 45'(longint'(pushed) << 8) : rand_word());
          pushed++;
          gap_cnt = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        end else begin
          gap_cnt--;
        end
      end
      cycle();
      budget++;
    end
    while (pushed < total) begin
      push_word(rand_word());
      pushed++;
    end
    chk("frame_done_count", n_done, 1);
    chk("frame_outputs", n_out, RPF);
    chk("frame_last_count", n_last, 1);
    chk("frame_sat_count", bus.sat_count, exp_sat);
    bus.out_ready = 1'b1;
    cycle();
    chk("busy_after_done", s_busy, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int b;
    int tbl_sat;
    logic [OUT_W-1:0] zero_w;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    zero_w = '0;

    // Rounding/saturation vectors (SHIFT=8, OUT_W=16).
    tbl[0]  = '{384, 2, 0};
    tbl[1]  = '{-385, -2, 0};
    tbl[2]  = '{longint'(1) << 40, 32767, 1};
    tbl[3]  = '{-(longint'(1) << 40), -32768, 1};
    tbl[4]  = '{127, 0, 0};
    tbl[5]  = '{128, 1, 0};
    tbl[6]  = '{-128, 0, 0};
    tbl[7]  = '{-129, -1, 0};
    tbl[8]  = '{8388352, 32767, 0};
    tbl[9]  = '{8388480, 32767, 1};
    tbl[10] = '{-8388608, -32768, 0};
    tbl[11] = '{-8388737, -32768, 1};
    tbl[12] = '{(longint'(1) << 44) - 1, 32767, 1};
    tbl[13] = '{-(longint'(1) << 44), -32768, 1};
    tbl[14] = '{0, 0, 0};

    @(posedge clk);
    #1;

    // Reset / idle with a non-empty FIFO.
    for (int k = 0; k < 3; k++) push_word(rand_word());
    first_en = -1; first_val = -1; first_hs = -1;
    for (int k = 0; k < 3; k++) cycle();
    chk("rst_fifo_en", bus.fifo_en, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_sat_count", bus.sat_count, 0);
    chk("rst_no_pop", rd_idx, 0);
    reset = 1'b1;
    drain_idle();

    // Nominal frame: k<<8 -> k, back to back.
    run_frame(0, 0, 15, 15, 0);
    chk("nom_latency", first_val - first_en, 2);
    chk("nom_back_to_back", last_hs - first_hs, RPF - 1);
    chk("nom_done_after_last", done_cyc - last_hs, 1);
    drain_idle();

    // Table-driven rounding and saturation.
    tbl_sat = 0;
    for (int i = 0; i < 15; i++) begin
      push_word(tbl[i].din[44:0]);
      tbl_sat += int'(tbl[i].sat);
    end
    sb_en = 1'b0;
    bus.out_ready = 1'b1;
    start_frame();
    for (int i = 0; i < 15; i++) begin
      b = 0;
      cycle();
      while (!hs && b < 50) begin
        cycle();
        b++;
      end
      if (!hs) begin
        chk("tbl_timeout", 0, 1);
      end else begin
        chk("tbl_data", longint'($signed(s_data)), tbl[i].dout);
        chk("tbl_last", s_last, (i == 14));
      end
    end
    b = 0;
    while (n_done == 0 && b < 20) begin
      cycle();
      b++;
    end
    chk("tbl_frame_done", n_done, 1);
    chk("tbl_sat_count", bus.sat_count, tbl_sat);
    sb_en = 1'b1;
    drain_idle();

    // Backpressure 1,0,0,1 with random data.
    run_frame(1, 1, 15, 15, 0);
    drain_idle();

    // Starved FIFO: one word every 4 cycles, 18 words total.
    run_frame(0, 1, 0, 18, 3);
    chk("starve_leftover_not_empty", bus.fifo_empty, 0);
    chk("starve_leftover_words", wr_idx - rd_idx, 3);
    drain_idle();

    // Random frames; leftover words roll into the next frame.
    for (int f = 0; f < 3; f++) begin
      run_frame(2, 1, int'($urandom_range(0, 15)), 15 + int'($urandom_range(0, 4)), -1);
    end
    drain_idle();

    // Reset mid-frame after 6 outputs.
    for (int k = 0; k < 15; k++) push_word(rand_word());
    bus.out_ready = 1'b1;
    start_frame();
    b = 0;
    while (n_out < 6 && b < 100) begin
      cycle();
      b++;
    end
    chk("mid_reach_six", n_out, 6);
    reset = 1'b0;
    cycle();
    sb_en = 1'b0;
    n_last = 0;
    n_done = 0;
    cycle();
    chk("mid_out_valid", s_valid, 0);
    chk("mid_out_data", longint'(s_data), longint'(zero_w));
    chk("mid_busy", s_busy, 0);
    chk("mid_fifo_en", s_en, 0);
    reset = 1'b1;
    cycle();
    cycle();
    chk("mid_no_last", n_last, 0);
    chk("mid_no_done", n_done, 0);
    drain_idle();
    sb_en = 1'b1;
    run_frame(0, 1, 15, 15, 0);
    drain_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
